// File: rtl/uart_pkg.sv
// Shared UART definitions: frame line levels, data width and transmit FSM state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic START_LEVEL    = 1'b0;
    localparam logic STOP_LEVEL     = 1'b1;
    localparam logic IDLE_LEVEL     = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, bit_tick on the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic          bit_tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign bit_tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO, one read pulse per frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    input  logic [UART_DATA_BITS-1:0] fifo_dout,
    output logic                      fifo_rd_en,
    output logic                      tx,
    output logic                      busy,
    output logic                      tx_done
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DONE_AT = CW'(CLKS_PER_BIT - 2);

    tx_state_e                 state, state_nxt;
    logic [UART_DATA_BITS-1:0] shift_q, shift_nxt;
    logic [2:0]                bit_idx, bit_idx_nxt;
    logic                      bit_tick, cnt_clear, tx_nxt;
    logic [CW-1:0]             baud_cnt;

    // Counter only runs while a bit is on the line, so it starts at 0 with the start bit.
    assign cnt_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .bit_tick (bit_tick),
        .cnt      (baud_cnt)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_idx_nxt = bit_idx;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD: begin
                shift_nxt   = fifo_dout;
                bit_idx_nxt = '0;
                state_nxt   = START;
            end
            START: if (bit_tick) state_nxt = DATA;
            DATA: if (bit_tick) begin
                shift_nxt   = shift_q >> 1;
                bit_idx_nxt = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP:    if (bit_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    always_comb begin
        case (state_nxt)
            START:   tx_nxt = START_LEVEL;
            DATA:    tx_nxt = shift_nxt[0];
            STOP:    tx_nxt = STOP_LEVEL;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_idx    <= '0;
            tx         <= IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            tx         <= tx_nxt;
            fifo_rd_en <= (state_nxt == FETCH);
            busy       <= (state_nxt != IDLE);
            tx_done    <= (state == STOP) && (baud_cnt == DONE_AT);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (16 and 2 clocks per bit), each fed by a queue FIFO.
module tb_fifo_uart_tx;

    localparam int C0 = 16;
    localparam int C1 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       empty0 = 1'b1, empty1 = 1'b1;
    logic [7:0] dout0 = 8'h00, dout1 = 8'h00;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_dout(dout0),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_dout(dout1),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    logic [7:0] q0[$], q1[$];
    int         checks = 0, errors = 0;
    int         cyc = 0;
    bit         act0 = 0, act1 = 0;
    int         t0_0 = 0, t0_1 = 0;
    logic [7:0] cur0 = 0, cur1 = 0;
    int         frames0 = 0, frames1 = 0, rd_cnt0 = 0, rd_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

    // Expected {rd_en, tx, busy, tx_done} at offset r from the cycle IDLE saw a byte.
    function automatic logic [3:0] exp_out(int c, int r, logic [7:0] b);
        logic rd, t, bz, dn;
        int   bitn;
        rd = (r == 1);
        bz = (r >= 1) && (r <= 3 + 10*c - 1);
        dn = (r == 3 + 10*c - 1);
        if (r < 3) t = 1'b1;
        else begin
            bitn = (r - 3) / c;
            if (bitn == 0)      t = 1'b0;
            else if (bitn <= 8) t = b[bitn-1];
            else                t = 1'b1;
        end
        return {rd, t, bz, dn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic push(input int lane, input logic [7:0] b);
        if (lane == 0) begin q0.push_back(b); empty0 = 1'b0; end
        else           begin q1.push_back(b); empty1 = 1'b0; end
    endtask

    function automatic bit idle0();
        return !act0 || (cyc - t0_0 >= 3 + 10*C0);
    endfunction

    function automatic bit idle1();
        return !act1 || (cyc - t0_1 >= 3 + 10*C1);
    endfunction

    // Model decides frame starts from what IDLE will see at the coming edge.
    task automatic tick();
        if (idle0()) begin
            act0 = (q0.size() != 0);
            if (act0) begin t0_0 = cyc; cur0 = q0[0]; frames0++; end
        end
        if (idle1()) begin
            act1 = (q1.size() != 0);
            if (act1) begin t0_1 = cyc; cur1 = q1[0]; frames1++; end
        end
        @(negedge clk);
        cyc++;
        chk("lane0", {28'd0, rd0, tx0, busy0, done0},
            {28'd0, act0 ? exp_out(C0, cyc - t0_0, cur0) : exp_out(C0, 0, 8'h00)});
        chk("lane1", {28'd0, rd1, tx1, busy1, done1},
            {28'd0, act1 ? exp_out(C1, cyc - t0_1, cur1) : exp_out(C1, 0, 8'h00)});
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        if (rd0) begin
            rd_cnt0++;
            if (q0.size() != 0) dout0 = q0.pop_front();
            empty0 = (q0.size() == 0);
        end
        if (rd1) begin
            rd_cnt1++;
            if (q1.size() != 0) dout1 = q1.pop_front();
            empty1 = (q1.size() == 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        frames0 = 0; frames1 = 0; rd_cnt0 = 0; rd_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_tx",   {30'd0, tx0, tx1},     32'h3);
        chk("rst_busy", {30'd0, busy0, busy1}, 32'h0);
        chk("rst_rd",   {30'd0, rd0, rd1},     32'h0);
        chk("rst_done", {30'd0, done0, done1}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // Single 0x55 frame: rd_en at cycle 1, tx_done at cycle 162.
        clear_counts();
        push(0, 8'h55);
        run(200);
        chk("t55_rd",   rd_cnt0,   1);
        chk("t55_done", done_cnt0, 1);

        // Back-to-back frames, second start exactly one frame period later.
        clear_counts();
        push(0, 8'hA5);
        push(0, 8'h3C);
        run(360);
        chk("b2b_rd",   rd_cnt0,   2);
        chk("b2b_done", done_cnt0, 2);

        // Long idle with an empty FIFO.
        run(500);

        // Reset during data bit 3 of 0xFF.
        clear_counts();
        push(0, 8'hFF);
        for (int i = 0; i < 400 && !(act0 && (cyc - t0_0 >= 3 + 4*C0 + 5)); i++) tick();
        chk("rst_reach", {31'd0, act0 && (cyc - t0_0 >= 3 + 4*C0 + 5)}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_tx",   {31'd0, tx0},   32'd1);
        chk("mid_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rd",   {31'd0, rd0},   32'd0);
        act0 = 0; act1 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_q_empty", q0.size(), 0);
        clear_counts();
        run(300);
        chk("post_rst_rd", rd_cnt0, 0);

        // Fastest rate: 0x00 and 0xFF, 20-cycle frames.
        clear_counts();
        push(1, 8'h00);
        push(1, 8'hFF);
        run(60);
        chk("c2_rd",   rd_cnt1,   2);
        chk("c2_done", done_cnt1, 2);

        // Random bytes arriving at arbitrary times, including mid-frame.
        clear_counts();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) push(0, 8'($urandom));
            if ($urandom_range(0, 24) == 0)  push(1, 8'($urandom));
            tick();
        end
        for (int i = 0; i < 4000 && !(q0.size() == 0 && q1.size() == 0 && idle0() && idle1()); i++)
            tick();
        chk("rnd_drained", {31'd0, q0.size() == 0 && q1.size() == 0 && idle0() && idle1()}, 32'd1);
        run(5);
        chk("rnd_rd0",   rd_cnt0,   frames0);
        chk("rnd_rd1",   rd_cnt1,   frames1);
        chk("rnd_done0", done_cnt0, frames0);
        chk("rnd_done1", done_cnt1, frames1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
